// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter byte port between
// N_REQ message sources. A grant is held for a whole message, and an idle
// gap of GAP_CYCLES clocks follows each message on the line.
module uart_tx_arbiter #(
   parameter int N_REQ      = 4,
   parameter int GAP_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   in_valid,
   input  logic [8*N_REQ-1:0] in_data,
   input  logic [N_REQ-1:0]   in_last,
   output logic [N_REQ-1:0]   in_ready,
   output logic               tx_valid,
   output logic [7:0]         tx_data,
   input  logic               tx_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               busy
);

   localparam int PTR_W = $clog2(N_REQ);
   // A zero-cycle gap still needs a 1-bit counter so the declaration is legal.
   localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN, ST_GAP} state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   gidx_q, gidx_d;      // binary index of the granted requester
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               tx_valid_q, tx_valid_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

   logic [PTR_W-1:0]   cand_idx [N_REQ];
   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic               can_take;
   logic               accept;
   logic [7:0]         sel_data;
   logic               sel_last;

   // Candidate gi is the requester gi positions after rr_ptr, wrapped modulo N_REQ.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [PTR_W:0] sum;
      assign sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                                                        : sum[PTR_W-1:0];
   end

   // Winner = first valid candidate in round-robin order; highest offset scanned first so the lowest offset wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (in_valid[cand_idx[k]]) begin
            win_found = 1'b1;
            win_idx   = cand_idx[k];
         end
      end
   end

   // The output register can take a byte when empty or when it is being drained this cycle.
   assign can_take = !tx_valid_q || tx_ready;
   assign in_ready = (state_q == ST_SEND && can_take) ? grant_q : '0;
   assign accept   = |(in_valid & in_ready);
   assign sel_data = in_data[{gidx_q, 3'b000} +: 8];
   assign sel_last = in_last[gidx_q];

   // Next-state, grant, output register and gap counter logic.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      gap_cnt_d  = gap_cnt_q;

      if (accept) begin
         tx_valid_d = 1'b1;
         tx_data_d  = sel_data;
      end else if (tx_ready) begin
         tx_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_d = N_REQ'(1) << win_idx;
               gidx_d  = win_idx;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (accept && sel_last) begin
               grant_d  = '0;
               rr_ptr_d = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
               state_d  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (tx_valid_q && tx_ready) begin
               if (GAP_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  gap_cnt_d = CNT_W'(GAP_CYCLES);
                  state_d   = ST_GAP;
               end
            end
         end
         default: begin
            gap_cnt_d = gap_cnt_q - 1'b1;
            if (gap_cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign grant    = grant_q;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected bytes in
// round-robin service order; an independent monitor pops them on every
// transmitter handshake. A second instance checks the zero-gap build.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int GAP = 16;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   in_valid;
   logic [8*N-1:0] in_data;
   logic [N-1:0]   in_last;
   logic [N-1:0]   in_ready;
   logic           tx_valid;
   logic [7:0]     tx_data;
   logic           tx_ready;
   logic [N-1:0]   grant;
   logic           busy;

   logic [N-1:0]   in_valid0;
   logic [8*N-1:0] in_data0;
   logic [N-1:0]   in_last0;
   logic [N-1:0]   in_ready0;
   logic           tx_valid0;
   logic [7:0]     tx_data0;
   logic           tx_ready0;
   logic [N-1:0]   grant0;
   logic           busy0;

   int checks;
   int errors;
   int model_ptr;

   logic [7:0] exp_q [$];
   logic [8:0] req_q [N][$];

   uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .grant(grant), .busy(busy)
   );

   uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_data(in_data0), .in_last(in_last0),
      .in_ready(in_ready0), .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready0),
      .grant(grant0), .busy(busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard on transmitter handshakes plus output-register hold and grant sanity.
   initial begin
      logic       hold;
      logic [7:0] hold_data;
      logic [7:0] e;
      hold = 1'b0;
      hold_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            checks++;
            if (((in_ready & ~grant) != '0) || !$onehot0(grant)) begin
               errors++;
               $display("FAIL grant_sanity: grant=%b in_ready=%b", grant, in_ready);
            end
            if (hold) begin
               checks++;
               if (!tx_valid || tx_data !== hold_data) begin
                  errors++;
                  $display("FAIL tx_hold: got valid=%0b data=0x%0h, expected valid=1 data=0x%0h",
                           tx_valid, tx_data, hold_data);
               end
            end
            if (tx_valid && tx_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
               end else begin
                  e = exp_q.pop_front();
                  if (tx_data !== e) begin
                     errors++;
                     $display("FAIL tx_byte: got 0x%0h, expected 0x%0h", tx_data, e);
                  end else begin
                     $display("tx byte 0x%0h ok", tx_data);
                  end
               end
            end
            hold      = tx_valid && !tx_ready;
            hold_data = tx_data;
         end
      end
   end

   function automatic bit pending();
      bit p;
      p = busy || (exp_q.size() != 0);
      for (int i = 0; i < N; i++) if (req_q[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   // Present each requester's head byte; granted requesters sometimes stall mid-message.
   task automatic present();
      logic [8:0] h;
      for (int i = 0; i < N; i++) begin
         if (req_q[i].size() > 0) begin
            h = req_q[i][0];
            in_valid[i]       = !(grant[i] && ($urandom_range(0, 3) == 0));
            in_data[8*i +: 8] = h[7:0];
            in_last[i]        = h[8];
         end else begin
            in_valid[i]       = 1'b0;
            in_data[8*i +: 8] = 8'($urandom);
            in_last[i]        = 1'($urandom);
         end
      end
      tx_ready = ($urandom_range(0, 9) < 7);
   endtask

   // Run requesters until every queued byte is sent and the arbiter is idle (bounded).
   task automatic drain();
      int           cyc;
      logic [N-1:0] acc;
      cyc = 0;
      do begin
         present();
         @(negedge clk);
         acc = in_valid & in_ready;
         step();
         for (int i = 0; i < N; i++) if (acc[i]) void'(req_q[i].pop_front());
         cyc++;
      end while (pending() && cyc < 3000);
      in_valid = '0;
      tx_ready = 1'b1;
      chk("drain_done", {31'b0, !pending()}, 32'd1);
   endtask

   // Reference model: all requesters in mask ask at once from idle, so they are served
   // once each in order of distance from the round-robin pointer.
   task automatic round(input logic [N-1:0] mask);
      int         i;
      int         len;
      int         last_srv;
      logic [7:0] b;
      last_srv = -1;
      for (int k = 0; k < N; k++) begin
         i = (model_ptr + k) % N;
         if (mask[i]) begin
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
               b = 8'($urandom);
               req_q[i].push_back({(j == len - 1), b});
               exp_q.push_back(b);
            end
            last_srv = i;
         end
      end
      if (last_srv >= 0) model_ptr = (last_srv + 1) % N;
      $display("round mask=%b queued=%0d next_ptr=%0d", mask, exp_q.size(), model_ptr);
      drain();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = '0; in_data = '0; in_last = '0; tx_ready = 1'b0;
      in_valid0 = '0; in_data0 = '0; in_last0 = '0; tx_ready0 = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) req_q[i].delete();
      model_ptr = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a;
      logic [7:0] b;
      checks = 0;
      errors = 0;
      do_reset();

      // Reset values
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_txvalid", tx_valid, 0);
      chk("rst_txdata", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_grant0", grant0, 0);
      step();

      // Zero-gap instance: two single-byte messages from requesters 0 and 1
      tx_ready0 = 1'b1;
      in_data0  = {16'h0, 8'hB1, 8'hA0};
      in_last0  = 4'b0011;
      for (int c = 0; c <= 6; c++) begin
         in_valid0 = (c <= 1) ? 4'b0011 : (c <= 4) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         chk("E_grant", grant0, (c == 1) ? 1 : (c == 4) ? 2 : 0);
         chk("E_ready", in_ready0, (c == 1) ? 1 : (c == 4) ? 2 : 0);
         chk("E_txvalid", tx_valid0, (c == 2 || c == 5));
         chk("E_busy", busy0, (c == 1 || c == 2 || c == 4 || c == 5));
         if (c == 2) chk("E_data1", tx_data0, 8'hA0);
         if (c == 5) chk("E_data2", tx_data0, 8'hB1);
         step();
      end

      // Requester 0: 0x41 0x42 0x43, tx_ready high
      tx_ready = 1'b1;
      exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
      for (int c = 0; c <= 21; c++) begin
         in_valid     = (c <= 3) ? 4'b0001 : 4'b0000;
         in_data[7:0] = (c <= 1) ? 8'h41 : (c == 2) ? 8'h42 : 8'h43;
         in_last[0]   = (c == 3);
         @(negedge clk);
         chk("A_grant", grant, (c >= 1 && c <= 3) ? 1 : 0);
         chk("A_ready", in_ready, (c >= 1 && c <= 3) ? 1 : 0);
         chk("A_txvalid", tx_valid, (c >= 2 && c <= 4));
         chk("A_busy", busy, (c >= 1 && c <= 20));
         step();
      end
      model_ptr = 1;

      // Requester 1 with transmitter stalled for 5 cycles on byte 0x55
      exp_q.push_back(8'h55); exp_q.push_back(8'h66);
      for (int c = 0; c <= 9; c++) begin
         in_valid      = (c <= 7) ? 4'b0010 : 4'b0000;
         in_data[15:8] = (c <= 1) ? 8'h55 : 8'h66;
         in_last[1]    = (c >= 2);
         tx_ready      = !(c >= 2 && c <= 6);
         @(negedge clk);
         chk("B_grant", grant, (c >= 1 && c <= 7) ? 2 : 0);
         chk("B_ready", in_ready, (c == 1 || c == 7) ? 2 : 0);
         chk("B_txvalid", tx_valid, (c >= 2 && c <= 8));
         if (c >= 2 && c <= 7) chk("B_hold_data", tx_data, 8'h55);
         if (c == 8) chk("B_next_data", tx_data, 8'h66);
         step();
      end
      drain();
      model_ptr = 2;

      // Fresh reset, then simultaneous 1&2, lone 3, then 0&3 wrap
      do_reset();
      round(4'b0110);
      round(4'b1000);
      round(4'b1001);

      // Randomized rounds
      for (int r = 0; r < 30; r++) round(4'($urandom_range(1, 15)));
      round(4'b0010);

      // Asynchronous reset during byte 2 of a 4-byte message from requester 0
      tx_ready = 1'b1;
      a = 8'($urandom);
      exp_q.push_back(a);
      in_valid = 4'b0001; in_data[7:0] = a; in_last = '0;
      @(negedge clk);
      chk("D_grant_c0", grant, 0);
      step();
      @(negedge clk);
      step();
      in_data[7:0] = 8'($urandom);
      @(negedge clk);
      chk("D_pre_txvalid", tx_valid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("D_rst_txvalid", tx_valid, 0);
      chk("D_rst_grant", grant, 0);
      chk("D_rst_busy", busy, 0);
      chk("D_rst_ready", in_ready, 0);
      in_valid = '0;
      exp_q.delete();
      model_ptr = 0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      step();

      // Requesters 0 and 2 after reset: pointer back at 0, so 0 wins with 2-cycle latency
      a = 8'($urandom);
      b = 8'($urandom);
      exp_q.push_back(a); exp_q.push_back(b);
      in_valid = 4'b0101; in_data[7:0] = a; in_data[23:16] = b; in_last = 4'b0101;
      @(negedge clk);
      chk("D_new_grant_c0", grant, 0);
      step();
      @(negedge clk);
      chk("D_new_grant_c1", grant, 1);
      chk("D_new_ready_c1", in_ready, 1);
      step();
      in_valid = 4'b0100;
      @(negedge clk);
      chk("D_new_txvalid_c2", tx_valid, 1);
      step();
      req_q[2].push_back({1'b1, b});
      model_ptr = 3;
      drain();
      round(4'b1111);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
